// File: rtl/dct_ft_math_if.sv
// rtl/dct_ft_math_if.sv - vector stream interface for dct_ft_math
interface dct_ft_math_if #(
    parameter int W_O = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic                 in_last;
    logic [7:0][15:0]     in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_last;
    logic [7:0][W_O-1:0]  out_data;

    modport master (
        output in_valid, in_last, in_data, out_ready,
        input  in_ready, out_valid, out_last, out_data
    );

    modport slave (
        input  in_valid, in_last, in_data, out_ready,
        output in_ready, out_valid, out_last, out_data
    );
endinterface

// File: rtl/dct_ft_math.sv
// rtl/dct_ft_math.sv - 8-point forward binDCT, 8 register stages, global stall; optional DCT_FT_LEVEL_SHIFT_EN
module dct_ft_math #(
    parameter int W_O = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    dct_ft_math_if.slave bus
);
    // 22-bit signed fixed point, 3 fraction bits
    typedef logic signed [21:0] fx_t;

    localparam int O_MAX = (1 << (W_O - 1)) - 1;
    localparam int O_MIN = -(1 << (W_O - 1));

    // round to integer value, ties away from zero; negative values need +3 so -x.5 goes down
    function automatic fx_t rnd(input fx_t v);
        fx_t t;
        t = v + (v[21] ? 22'sd3 : 22'sd4);
        return t & ~22'sd7;
    endfunction

    function automatic fx_t m38(input fx_t v);
        return (v >>> 2) + (v >>> 3);
    endfunction

    function automatic fx_t m58(input fx_t v);
        return (v >>> 1) + (v >>> 3);
    endfunction

    function automatic fx_t m78(input fx_t v);
        return (v >>> 1) + (v >>> 2) + (v >>> 3);
    endfunction

    // drop the fraction bits and clamp to the output lane width
    function automatic logic [W_O-1:0] sat(input fx_t v);
        int iv;
        iv = int'(v >>> 3);
        if (iv > O_MAX) begin
            iv = O_MAX;
        end else if (iv < O_MIN) begin
            iv = O_MIN;
        end
        return W_O'(iv);
    endfunction

    // st_q[0] = capture, st_q[1..6] = F1..F6; the output stage is out_data_q
    fx_t                 st_q [7][8];
    fx_t                 st_d [7][8];
    fx_t                 fn   [7][8];
    logic [7:0]          vld_q, vld_d;
    logic [7:0]          lst_q, lst_d;
    logic [7:0][W_O-1:0] out_data_q, out_data_d, out_fn;
    logic                adv;

    assign adv          = ~vld_q[7] | bus.out_ready;
    assign bus.in_ready = adv;
    assign bus.out_valid = vld_q[7];
    assign bus.out_last  = lst_q[7];
    assign bus.out_data  = out_data_q;

    // per-stage arithmetic, each stage fed from the register ahead of it
    always_comb begin
        logic signed [16:0] smp;
        smp = '0;
        for (int k = 1; k < 7; k++) begin
            for (int i = 0; i < 8; i++) begin
                fn[k][i] = st_q[k-1][i];
            end
        end
        for (int i = 0; i < 8; i++) begin
            smp = {bus.in_data[i][15], bus.in_data[i]};
`ifdef DCT_FT_LEVEL_SHIFT_EN
            smp = smp - 17'sd128;
`endif
            fn[0][i] = {{2{smp[16]}}, smp, 3'b000};
        end
        for (int i = 0; i < 4; i++) begin
            fn[1][i]     = st_q[0][i] + st_q[0][7-i];
            fn[1][7-i]   = st_q[0][i] - st_q[0][7-i];
        end
        fn[2][6] = st_q[1][6] + rnd(m38(st_q[1][5]));
        fn[3][5] = rnd(m58(st_q[2][6])) - st_q[2][5];
        fn[4][0] = st_q[3][0] + st_q[3][3];
        fn[4][3] = st_q[3][0] - st_q[3][3];
        fn[4][1] = st_q[3][1] + st_q[3][2];
        fn[4][2] = st_q[3][1] - st_q[3][2];
        fn[4][4] = st_q[3][4] + st_q[3][5];
        fn[4][5] = st_q[3][4] - st_q[3][5];
        fn[4][6] = st_q[3][7] - st_q[3][6];
        fn[4][7] = st_q[3][7] + st_q[3][6];
        fn[5][0] = st_q[4][0] + st_q[4][1];
        fn[5][2] = st_q[4][2] - rnd(m38(st_q[4][3]));
        fn[5][4] = st_q[4][4] - rnd(st_q[4][7] >>> 3);
        fn[5][5] = st_q[4][5] + rnd(m78(st_q[4][6]));
        fn[6][1] = rnd(st_q[5][0] >>> 1) - st_q[5][1];
        fn[6][3] = st_q[5][3] + rnd(m38(st_q[5][2]));
        fn[6][6] = st_q[5][6] - rnd(st_q[5][5] >>> 1);
        out_fn[0] = sat(st_q[6][0]);
        out_fn[1] = sat(st_q[6][7]);
        out_fn[2] = sat(st_q[6][3]);
        out_fn[3] = sat(st_q[6][6]);
        out_fn[4] = sat(st_q[6][1]);
        out_fn[5] = sat(st_q[6][5]);
        out_fn[6] = sat(st_q[6][2]);
        out_fn[7] = sat(st_q[6][4]);
    end

    // whole pipe moves together or holds together
    always_comb begin
        st_d       = st_q;
        vld_d      = vld_q;
        lst_d      = lst_q;
        out_data_d = out_data_q;
        if (adv) begin
            st_d       = fn;
            vld_d      = {vld_q[6:0], bus.in_valid};
            lst_d      = {lst_q[6:0], bus.in_last & bus.in_valid};
            out_data_d = out_fn;
        end
    end

    // stage registers, cleared asynchronously so in-flight vectors are dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 7; k++) begin
                for (int i = 0; i < 8; i++) begin
                    st_q[k][i] <= '0;
                end
            end
            vld_q      <= '0;
            lst_q      <= '0;
            out_data_q <= '0;
        end else begin
            for (int k = 0; k < 7; k++) begin
                for (int i = 0; i < 8; i++) begin
                    st_q[k][i] <= st_d[k][i];
                end
            end
            vld_q      <= vld_d;
            lst_q      <= lst_d;
            out_data_q <= out_data_d;
        end
    end
endmodule

// File: tb/tb_dct_ft_math.sv
// tb/tb_dct_ft_math.sv - directed-vector bench for dct_ft_math
module tb_dct_ft_math;
    localparam int W_A = 16;
    localparam int W_B = 12;
`ifdef DCT_FT_LEVEL_SHIFT_EN
    localparam int LS_BIAS = 128;
    localparam int DC128   = 0;
`else
    localparam int LS_BIAS = 0;
    localparam int DC128   = 1024;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk = 0;
    int   n_err = 0;
    int   n_out = 0;
    int   s_c = 0;
    int   first_out_c = -1;
    logic mon_en = 1'b0;

    always #5 clk = ~clk;

    dct_ft_math_if #(.W_O(W_A)) bus_a ();
    dct_ft_math_if #(.W_O(W_B)) bus_b ();

    dct_ft_math #(.W_O(W_A)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
    dct_ft_math #(.W_O(W_B)) u_sat (.clk(clk), .rst_n(rst_n), .bus(bus_b.slave));

    int vin [6][8] = '{
        '{0, 0, 0, 0, 0, 0, 0, 0},
        '{10, 10, 10, 10, 10, 10, 10, 10},
        '{128, 128, 128, 128, 128, 128, 128, 128},
        '{1, 0, 0, 0, 0, 0, 0, 0},
        '{0, 0, 0, 0, 0, 0, 0, 1},
        '{0, 1, 0, 0, 0, 0, 0, 0}
    };
    int vbias [6] = '{LS_BIAS, LS_BIAS, 0, LS_BIAS, LS_BIAS, LS_BIAS};
    int vexp [6][8] = '{
        '{0, 0, 0, 0, 0, 0, 0, 0},
        '{80, 0, 0, 0, 0, 0, 0, 0},
        '{DC128, 0, 0, 0, 0, 0, 0, 0},
        '{1, 1, 1, 0, 1, 1, 0, 0},
        '{1, -1, 1, 0, 1, -1, 0, 0},
        '{1, 1, 0, 0, 0, -2, 1, 1}
    };

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_vec(input int v);
        for (int i = 0; i < 8; i++) begin
            bus_a.in_data[i] = 16'(vin[v][i] + vbias[v]);
        end
    endtask

    task automatic run_single(input int v, input string tag);
        int lat;
        @(posedge clk); #1;
        set_vec(v);
        bus_a.in_valid = 1'b1;
        bus_a.in_last  = 1'b1;
        check({tag, "_in_ready"}, 32'(bus_a.in_ready), 1);
        @(posedge clk); #1;
        bus_a.in_valid = 1'b0;
        bus_a.in_last  = 1'b0;
        lat = 1;
        while (!bus_a.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, lat, 8);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("%s_x%0d", tag, k), $signed(bus_a.out_data[k]), vexp[v][k]);
        end
        check({tag, "_last"}, 32'(bus_a.out_last), 1);
    endtask

    // output scoreboard for the back-to-back stream
    always @(negedge clk) begin
        if (mon_en && bus_a.out_valid && bus_a.out_ready) begin
            if (n_out == 0) first_out_c = s_c;
            if (n_out < 10) begin
                for (int k = 0; k < 8; k++) begin
                    check($sformatf("strm%0d_x%0d", n_out, k), $signed(bus_a.out_data[k]), vexp[n_out % 6][k]);
                end
                check($sformatf("strm%0d_last", n_out), 32'(bus_a.out_last), 32'(n_out % 3 == 2));
            end
            n_out++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int j;
        int c;
        int w;
        logic seen;
        bus_a.in_valid = 1'b0; bus_a.in_last = 1'b0; bus_a.in_data = '0; bus_a.out_ready = 1'b0;
        bus_b.in_valid = 1'b0; bus_b.in_last = 1'b0; bus_b.in_data = '0; bus_b.out_ready = 1'b1;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("rst_out_valid", 32'(bus_a.out_valid), 0);
        check("rst_out_last", 32'(bus_a.out_last), 0);
        check("rst_out_data", 32'(bus_a.out_data[0] | bus_a.out_data[5]), 0);
        check("rst_in_ready", 32'(bus_a.in_ready), 1);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        bus_a.out_ready = 1'b1;

        for (int v = 0; v < 6; v++) begin
            run_single(v, $sformatf("vec%0d", v));
        end

        // ten back-to-back vectors, consumer stalls cycles 9..11
        repeat (3) @(posedge clk);
        #1;
        j = 0; c = 0; n_out = 0; mon_en = 1'b1;
        while ((j < 10 || n_out < 10) && c < 40) begin
            s_c = c;
            bus_a.out_ready = !(c >= 9 && c < 12);
            if (j < 10) begin
                set_vec(j % 6);
                bus_a.in_valid = 1'b1;
                bus_a.in_last  = (j % 3 == 2);
            end else begin
                bus_a.in_valid = 1'b0;
                bus_a.in_last  = 1'b0;
            end
            @(negedge clk);
            if (c >= 9 && c < 12) begin
                check($sformatf("stall%0d_in_ready", c), 32'(bus_a.in_ready), 0);
                check($sformatf("stall%0d_out_valid", c), 32'(bus_a.out_valid), 1);
                check($sformatf("stall%0d_last", c), 32'(bus_a.out_last), 0);
                for (int k = 0; k < 8; k++) begin
                    check($sformatf("stall%0d_x%0d", c, k), $signed(bus_a.out_data[k]), vexp[1][k]);
                end
            end
            if (bus_a.in_valid && bus_a.in_ready) j++;
            @(posedge clk); #1;
            c++;
        end
        bus_a.in_valid = 1'b0;
        bus_a.in_last  = 1'b0;
        bus_a.out_ready = 1'b1;
        check("strm_first_out_cycle", first_out_c, 8);
        repeat (6) @(posedge clk);
        #1;
        check("strm_count", n_out, 10);
        mon_en = 1'b0;

        // reset with three vectors in flight
        for (int q = 0; q < 3; q++) begin
            @(posedge clk); #1;
            set_vec(1);
            bus_a.in_valid = 1'b1;
        end
        @(posedge clk); #1;
        bus_a.in_valid = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("flight_rst_out_valid", 32'(bus_a.out_valid), 0);
        check("flight_rst_in_ready", 32'(bus_a.in_ready), 1);
        @(negedge clk) rst_n = 1'b1;
        seen = 1'b0;
        for (int q = 0; q < 12; q++) begin
            @(posedge clk); #1;
            if (bus_a.out_valid) seen = 1'b1;
        end
        check("flight_no_ghost", 32'(seen), 0);
        run_single(5, "post_rst");

        // saturation on the 12-bit instance
        for (int q = 0; q < 4; q++) begin
            @(posedge clk); #1;
            bus_b.in_valid = 1'b1;
            bus_b.in_last  = (q == 3);
            for (int i = 0; i < 8; i++) begin
                bus_b.in_data[i] = (q % 2 == 0) ? 16'h7fff : 16'h8000;
            end
        end
        @(posedge clk); #1;
        bus_b.in_valid = 1'b0;
        w = 0;
        while (!bus_b.out_valid && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        check("sat_seen", 32'(bus_b.out_valid), 1);
        for (int q = 0; q < 4; q++) begin
            check($sformatf("sat%0d_x0", q), $signed(bus_b.out_data[0]), (q % 2 == 0) ? 2047 : -2048);
            for (int k = 1; k < 8; k++) begin
                check($sformatf("sat%0d_x%0d", q, k), $signed(bus_b.out_data[k]), 0);
            end
            @(posedge clk); #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
